// File: rtl/fetch_ctrl.sv
// fetch_ctrl: stage-1 PC sequencer with imem handshake, wrong-path flush and sticky fetch error.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  output logic        pc_src,
  output logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic        flush,
  output logic        fetch_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {BOOT, FETCH, WAIT_MEM, DRAIN, ERROR} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          act;
  logic          live;
  logic          mis;
  logic          tmo;
  assign act         = state == FETCH || state == WAIT_MEM;
  assign live        = act || state == DRAIN;
  assign mis         = br_taken && br_target[1:0] != 2'b00;
  assign tmo         = cnt == CW'(MEM_TIMEOUT);
  // saturate so a redirect at the timeout boundary cannot wrap the counter in DRAIN
  assign cnt_inc     = tmo ? cnt : cnt + 1'b1;
  assign if_valid    = act && imem_ready && !id_stall && !br_taken;
  assign pc_src      = !if_valid;
  assign branch_addr = state == BOOT ? RESET_VEC : (live && br_taken && !mis) ? br_target : pc_addr;
  assign imem_req    = act;
  assign imem_addr   = pc_addr;
  assign flush       = live && br_taken;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH, WAIT_MEM: begin
          if (mis) begin
            state     <= ERROR;
            fetch_err <= 1'b1;
          end else if (imem_ready) begin
            state <= FETCH;
            cnt   <= '0;
          end else if (state == WAIT_MEM && tmo && !br_taken) begin
            state     <= ERROR;
            fetch_err <= 1'b1;
          end else begin
            state <= br_taken ? DRAIN : WAIT_MEM;
            cnt   <= state == FETCH ? CW'(1) : cnt_inc;
          end
        end
        DRAIN: begin
          if (mis || (!imem_ready && tmo)) begin
            state     <= ERROR;
            fetch_err <= 1'b1;
          end else if (imem_ready) begin
            state <= FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl driving a behavioural PC register.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_addr;
  logic        pc_src;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        id_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        if_valid;
  logic        flush;
  logic        fetch_err;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_ctrl #(.RESET_VEC(32'h0000_0000), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_src(pc_src),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .id_stall(id_stall), .br_taken(br_taken),
    .br_target(br_target), .if_valid(if_valid), .flush(flush), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // PC register resets to a junk value so the BOOT load of RESET_VEC is visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_addr <= 32'hFFFF_FFF0;
    else        pc_addr <= pc_src ? branch_addr : pc_addr + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    imem_ready = rdy;
    id_stall   = stl;
    br_taken   = br;
    br_target  = tgt;
    #1;
  endtask

  initial begin
    // reset held: BOOT outputs
    drive(1, 0, 1, 32'h40);
    chk("rst_pc_src", pc_src, 1);
    chk("rst_baddr", branch_addr, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_err", fetch_err, 0);
    reset = 1'b1;
    chk("boot_pc_src", pc_src, 1);
    chk("boot_flush", flush, 0);
    // streaming fetch 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      chk($sformatf("stream_addr%0d", i), imem_addr, 32'(i * 4));
      chk($sformatf("stream_valid%0d", i), if_valid, 1);
      chk($sformatf("stream_req%0d", i), imem_req, 1);
      chk($sformatf("stream_src%0d", i), pc_src, 0);
    end
    // memory stall at 0x10 for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk($sformatf("wait_addr%0d", i), imem_addr, 32'h10);
      chk($sformatf("wait_src%0d", i), pc_src, 1);
      chk($sformatf("wait_baddr%0d", i), branch_addr, 32'h10);
      chk($sformatf("wait_valid%0d", i), if_valid, 0);
      chk($sformatf("wait_req%0d", i), imem_req, 1);
    end
    drive(1, 0, 0, 0);
    chk("wait_done_valid", if_valid, 1);
    chk("wait_done_src", pc_src, 0);
    drive(0, 0, 0, 0);
    chk("adv_0x14", imem_addr, 32'h14);
    // branch while waiting, response two cycles later
    drive(0, 0, 1, 32'h100);
    chk("wbr_flush", flush, 1);
    chk("wbr_src", pc_src, 1);
    chk("wbr_baddr", branch_addr, 32'h100);
    chk("wbr_valid", if_valid, 0);
    drive(0, 0, 0, 0);
    chk("drain_req", imem_req, 0);
    chk("drain_flush", flush, 0);
    chk("drain_valid", if_valid, 0);
    chk("drain_hold", branch_addr, 32'h100);
    drive(1, 0, 0, 0);
    chk("drain_rdy_req", imem_req, 0);
    chk("drain_rdy_valid", if_valid, 0);
    drive(1, 0, 0, 0);
    chk("post_drain_addr", imem_addr, 32'h100);
    chk("post_drain_req", imem_req, 1);
    chk("post_drain_valid", if_valid, 1);
    // redirect to 0x20 from FETCH with a ready response discarded
    drive(1, 0, 1, 32'h20);
    chk("fbr_flush", flush, 1);
    chk("fbr_valid", if_valid, 0);
    // ID stall two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0);
      chk($sformatf("stall_addr%0d", i), imem_addr, 32'h20);
      chk($sformatf("stall_valid%0d", i), if_valid, 0);
      chk($sformatf("stall_baddr%0d", i), branch_addr, 32'h20);
      chk($sformatf("stall_src%0d", i), pc_src, 1);
    end
    drive(1, 0, 0, 0);
    chk("unstall_valid", if_valid, 1);
    // misaligned target
    drive(1, 0, 1, 32'h102);
    chk("mis_addr", imem_addr, 32'h24);
    chk("mis_flush", flush, 1);
    chk("mis_src", pc_src, 1);
    chk("mis_baddr", branch_addr, 32'h24);
    chk("mis_err_pre", fetch_err, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h200);
      chk($sformatf("err_sticky%0d", i), fetch_err, 1);
      chk($sformatf("err_pc%0d", i), pc_addr, 32'h24);
      chk($sformatf("err_req%0d", i), imem_req, 0);
      chk($sformatf("err_flush%0d", i), flush, 0);
      chk($sformatf("err_valid%0d", i), if_valid, 0);
      chk($sformatf("err_baddr%0d", i), branch_addr, 32'h24);
    end
    // reset out of ERROR, clears asynchronously
    reset = 1'b0;
    #1;
    chk("err_async_clr", fetch_err, 0);
    chk("err_rst_baddr", branch_addr, 32'h0);
    drive(1, 0, 0, 0);
    reset = 1'b1;
    drive(1, 0, 0, 0);
    chk("reboot_addr", imem_addr, 32'h0);
    chk("reboot_valid", if_valid, 1);
    // timeout: one FETCH miss then four WAIT_MEM cycles
    drive(0, 0, 0, 0);
    chk("tmo_fetch_err", fetch_err, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0);
      chk($sformatf("tmo_wait_err%0d", i), fetch_err, 0);
      chk($sformatf("tmo_wait_req%0d", i), imem_req, 1);
    end
    drive(0, 0, 0, 0);
    chk("tmo_err", fetch_err, 1);
    chk("tmo_req", imem_req, 0);
    drive(1, 0, 0, 0);
    chk("tmo_sticky", fetch_err, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("tmo_async_clr", fetch_err, 0);
    // reset mid-request returns to BOOT outputs without a clock edge
    drive(1, 0, 0, 0);
    reset = 1'b1;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("mid_req_pre", imem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_req_rst", imem_req, 0);
    chk("mid_src_rst", pc_src, 1);
    chk("mid_baddr_rst", branch_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
